fifo_ctrl: RTL and testbench

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_ctrl_pkg.sv | 14 +
 rtl/fifo_ctrl_ptr_counter.sv | 22 ++
 rtl/fifo_ctrl.sv | 100 ++++++++++
 tb/tb_fifo_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared FIFO constants and controller state encoding.
// Used by the pointer/occupancy controller and the FIFO memory alongside it.
package fifo_ctrl_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_PTR_W = 2;
    localparam int FIFO_CNT_W = 3;

    typedef enum logic {
        EMPTY_OR_ACTIVE = 1'b0,
        ERROR           = 1'b1
    } fifo_state_t;

endpackage

// File: rtl/fifo_ctrl_ptr_counter.sv
// Enabled wrapping pointer register with synchronous reset.
// Wraps naturally at 2**W because the register is exactly W bits wide.
module ptr_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] PTR_ONE = W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (en) begin
            value <= value + PTR_ONE;
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO pointer/occupancy controller: drives memory write/read strobes and slot pointers,
// tracks occupancy, and latches a sticky error on push-while-full or pop-while-empty.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int PTR_W = FIFO_PTR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             add_fifo,
    input  logic             pop_fifo,
    output logic [PTR_W-1:0] write_ptr,
    output logic [PTR_W-1:0] read_ptr,
    output logic             write,
    output logic             read,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic [PTR_W:0]   count,
    output logic             err
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(2 ** PTR_W);
    localparam logic [PTR_W:0] CNT_ONE    = (PTR_W + 1)'(1);

    fifo_state_t state;
    fifo_state_t state_nxt;

    logic push_ok;
    logic pop_ok;
    logic violation;

    // Full/empty come from the occupancy count; pointers alone cannot tell full from empty.
    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);

    // A pop frees a slot in the same cycle, so push+pop is accepted even when full.
    assign push_ok = add_fifo & (~fifo_full | pop_fifo) & ~rst;
    assign pop_ok  = pop_fifo & ~fifo_empty & ~rst;

    assign write = push_ok;
    assign read  = pop_ok;

    // Push+pop while empty is a legal push (the pop just has nothing to take), not a violation.
    assign violation = (add_fifo & fifo_full & ~pop_fifo)
                     | (pop_fifo & fifo_empty & ~add_fifo);

    ptr_counter #(.W(PTR_W)) u_write_ptr (
        .clk   (clk),
        .rst   (rst),
        .en    (push_ok),
        .value (write_ptr)
    );

    ptr_counter #(.W(PTR_W)) u_read_ptr (
        .clk   (clk),
        .rst   (rst),
        .en    (pop_ok),
        .value (read_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY_OR_ACTIVE;
        end else begin
            state <= state_nxt;
        end
    end

    // ERROR only exits via reset; push/pop servicing is unaffected by the state.
    always_comb begin
        state_nxt = state;
        err       = 1'b0;
        case (state)
            EMPTY_OR_ACTIVE: begin
                if (violation) begin
                    state_nxt = ERROR;
                end
            end
            ERROR: begin
                err = 1'b1;
            end
            default: begin
                state_nxt = EMPTY_OR_ACTIVE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl: a queue-of-entries reference model predicts every cycle,
// and a negedge monitor pops predictions and compares them with the DUT outputs.
module tb_fifo_ctrl;

    logic       clk;
    logic       rst;
    logic       add_fifo;
    logic       pop_fifo;
    logic [1:0] write_ptr;
    logic [1:0] read_ptr;
    logic       write;
    logic       read;
    logic       fifo_full;
    logic       fifo_empty;
    logic [2:0] count;
    logic       err;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [1:0] wp;
        logic [1:0] rp;
        logic [2:0] cnt;
        logic       full;
        logic       empty;
        logic       err;
    } expect_t;

    expect_t exp_q[$];

    // Reference model: contents as a queue of ids, plus running totals of accepted ops.
    int model_q[$];
    int push_total;
    int pop_total;
    int next_id;
    bit model_err;

    int checks;
    int errors;

    fifo_ctrl #(.PTR_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .add_fifo   (add_fifo),
        .pop_fifo   (pop_fifo),
        .write_ptr  (write_ptr),
        .read_ptr   (read_ptr),
        .write      (write),
        .read       (read),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .count      (count),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic apply_stimulus(input bit a, input bit p, input bit r);
        expect_t e;
        bit      full_m;
        bit      empty_m;
        bit      push_acc;
        bit      pop_acc;
        @(posedge clk);
        #2;
        add_fifo = a;
        pop_fifo = p;
        rst      = r;
        full_m   = (model_q.size() == 4);
        empty_m  = (model_q.size() == 0);
        push_acc = !r && a && (!full_m || p);
        pop_acc  = !r && p && !empty_m;
        e.wr    = push_acc;
        e.rd    = pop_acc;
        e.wp    = 2'(push_total % 4);
        e.rp    = 2'(pop_total % 4);
        e.cnt   = 3'(model_q.size());
        e.full  = full_m;
        e.empty = empty_m;
        e.err   = model_err;
        exp_q.push_back(e);
        if (r) begin
            model_q.delete();
            push_total = 0;
            pop_total  = 0;
            model_err  = 1'b0;
        end else begin
            if ((a && full_m && !p) || (p && empty_m && !a)) model_err = 1'b1;
            if (pop_acc) begin
                void'(model_q.pop_front());
                pop_total++;
            end
            if (push_acc) begin
                model_q.push_back(next_id);
                next_id++;
                push_total++;
            end
        end
    endtask

    initial begin : monitor
        expect_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("write",      32'(write),      32'(e.wr));
                check_output("read",       32'(read),       32'(e.rd));
                check_output("write_ptr",  32'(write_ptr),  32'(e.wp));
                check_output("read_ptr",   32'(read_ptr),   32'(e.rp));
                check_output("count",      32'(count),      32'(e.cnt));
                check_output("fifo_full",  32'(fifo_full),  32'(e.full));
                check_output("fifo_empty", 32'(fifo_empty), 32'(e.empty));
                check_output("err",        32'(err),        32'(e.err));
            end
        end
    end

    initial begin : stimulus
        checks     = 0;
        errors     = 0;
        push_total = 0;
        pop_total  = 0;
        next_id    = 0;
        model_err  = 1'b0;
        rst        = 1'b1;
        add_fifo   = 1'b0;
        pop_fifo   = 1'b0;
        @(posedge clk);

        apply_stimulus(0, 0, 1);
        repeat (4) apply_stimulus(1, 0, 0);
        apply_stimulus(1, 0, 0);
        apply_stimulus(0, 0, 0);
        repeat (3) apply_stimulus(1, 1, 0);
        repeat (4) apply_stimulus(0, 1, 0);
        apply_stimulus(0, 0, 1);
        apply_stimulus(1, 1, 0);
        apply_stimulus(0, 1, 0);
        apply_stimulus(0, 1, 0);
        apply_stimulus(0, 0, 0);
        repeat (2) apply_stimulus(1, 0, 0);
        apply_stimulus(0, 0, 1);
        apply_stimulus(0, 0, 0);
        apply_stimulus(0, 1, 0);
        apply_stimulus(0, 0, 0);

        for (int i = 0; i < 1000; i++) begin
            apply_stimulus($urandom_range(0, 99) < 55,
                           $urandom_range(0, 99) < 45,
                           $urandom_range(0, 199) == 0);
        end
        apply_stimulus(0, 0, 0);

        repeat (3) @(posedge clk);
        check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
